// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// md_op/a/b/d_md_use are sampled every cycle; results are plain levels (no handshake).
interface mdu_if;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output md_op, a, b, d_md_use,
    input  busy, stall_req, md_out, hi, lo, dbg_state
  );

  modport slave (
    input  md_op, a, b, d_md_use,
    output busy, stall_req, md_out, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit with private HI/LO registers.
// The result is computed at start and held in {r_ph,r_pl} until the countdown commits it.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   rst,
  mdu_if.slave   bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_ph, r_pl;
  logic          r_supp;

  logic          w_is_muldiv, w_is_mult, w_is_div, w_start, w_last;
  logic [63:0]   w_sa, w_sb, w_prod_s, w_prod_u, w_result;
  logic [31:0]   w_a_mag, w_b_mag, w_dvd, w_dvs, w_q, w_r, w_q_fin, w_r_fin;
  logic          w_signed_div;

  assign w_is_muldiv = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);
  assign w_is_mult   = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
  assign w_is_div    = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
  assign w_start     = (r_state == S_IDLE) && w_is_muldiv;
  assign w_last      = (r_state == S_BUSY) && (r_cnt == CW'(1));

  assign w_sa     = {{32{bus.a[31]}}, bus.a};
  assign w_sb     = {{32{bus.b[31]}}, bus.b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = {32'b0, bus.a} * {32'b0, bus.b};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with no overflow trap.
  assign w_signed_div = (bus.md_op == OP_DIV);
  assign w_a_mag = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag = bus.b[31] ? (32'd0 - bus.b) : bus.b;
  assign w_dvd   = w_signed_div ? w_a_mag : bus.a;
  assign w_dvs   = w_signed_div ? w_b_mag : bus.b;
  assign w_q     = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
  assign w_r     = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
  assign w_q_fin = (w_signed_div && (bus.a[31] ^ bus.b[31])) ? (32'd0 - w_q) : w_q;
  assign w_r_fin = (w_signed_div && bus.a[31]) ? (32'd0 - w_r) : w_r;

  always_comb begin
    w_result = {w_r_fin, w_q_fin};
    case (bus.md_op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      default:  w_result = {w_r_fin, w_q_fin};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_BUSY;
      S_BUSY:  if (w_last)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_ph   <= '0;
      r_pl   <= '0;
      r_supp <= 1'b0;
    end else if (w_start) begin
      r_ph   <= w_result[63:32];
      r_pl   <= w_result[31:0];
      r_cnt  <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      r_supp <= w_is_div && (bus.b == 32'd0);
    end else if (r_state == S_BUSY) begin
      if (w_last) begin
        r_cnt <= '0;
        if (!r_supp) begin
          r_hi <= r_ph;
          r_lo <= r_pl;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end else if (bus.md_op == OP_MTHI) begin
      r_hi <= bus.a;
    end else if (bus.md_op == OP_MTLO) begin
      r_lo <= bus.a;
    end
  end

  always_comb begin
    bus.md_out = 32'd0;
    if (bus.md_op == OP_MFHI)      bus.md_out = r_hi;
    else if (bus.md_op == OP_MFLO) bus.md_out = r_lo;
  end

  assign bus.busy      = (r_state == S_BUSY);
  assign bus.stall_req = bus.d_md_use & ((r_state == S_BUSY) | w_is_muldiv);
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed cases plus random ops against a plain-arithmetic model;
// a monitor pops expected HI/LO and busy length whenever busy falls.
module tb_mdu;
  logic clk;
  logic rst;
  mdu_if u_if();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  int          dur_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (op)
      4'd1: begin q = sx * sy; return q; end
      4'd2: return ux * uy;
      4'd3: begin
        if (y == 32'd0) return {m_hi, m_lo};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (y == 32'd0) return {m_hi, m_lo};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Monitor: counts busy cycles and checks the committed HI/LO on the cycle busy drops.
  int   mon_cnt = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      mon_cnt  = 0;
      mon_prev = 1'b0;
      exp_q.delete();
      dur_q.delete();
    end else begin
      if (u_if.busy) begin
        mon_cnt++;
      end else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_commit", 64'(exp_q.size()), 64'd1);
        end else begin
          check("sb_hilo", {u_if.hi, u_if.lo}, exp_q.pop_front());
          check("sb_busy_len", 64'(mon_cnt), 64'(dur_q.pop_front()));
        end
        mon_cnt = 0;
      end
      mon_prev = u_if.busy;
    end
  end

  // Drives one op for exactly one edge; assumes the unit is idle.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    u_if.md_op = op;
    u_if.a     = x;
    u_if.b     = y;
    #1;
    if (op == 4'd7) check("mfhi", {32'd0, u_if.md_out}, {32'd0, m_hi});
    if (op == 4'd8) check("mflo", {32'd0, u_if.md_out}, {32'd0, m_lo});
    if (op >= 4'd1 && op <= 4'd4) begin
      logic [63:0] e;
      e = model(op, x, y);
      exp_q.push_back(e);
      dur_q.push_back((op <= 4'd2) ? 5 : 10);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    if (op == 4'd5) m_hi = x;
    if (op == 4'd6) m_lo = x;
    @(posedge clk); #1;
    u_if.md_op = 4'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (u_if.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {63'd0, u_if.busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials[5];
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] old_lo;
    logic [3:0]  op;
    rst = 1'b0;
    u_if.md_op = 4'd0;
    u_if.a = 32'd0;
    u_if.b = 32'd0;
    u_if.d_md_use = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, u_if.busy}, 64'd0);
    check("rst_hilo", {u_if.hi, u_if.lo}, 64'd0);
    check("rst_stall", {63'd0, u_if.stall_req}, 64'd0);
    check("rst_md_out", {32'd0, u_if.md_out}, 64'd0);
    u_if.d_md_use = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle();
    check("mult_neg", {u_if.hi, u_if.lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle();
    check("multu", {u_if.hi, u_if.lo}, 64'h00000002_FFFFFFFA);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    check("div_neg", {u_if.hi, u_if.lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle();
    check("divu", {u_if.hi, u_if.lo}, 64'h00000001_00000003);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    check("div_ovf", {u_if.hi, u_if.lo}, 64'h00000000_80000000);

    issue(4'd5, 32'h12345678, 32'd0);
    issue(4'd6, 32'h9ABCDEF0, 32'd0);
    issue(4'd4, 32'd99, 32'd0);
    wait_idle();
    check("divz_keep", {u_if.hi, u_if.lo}, 64'h12345678_9ABCDEF0);
    issue(4'd7, 32'd0, 32'd0);

    // Stall window and an ignored MTLO while the multiply is in flight.
    old_lo = m_lo;
    u_if.d_md_use = 1'b1;
    u_if.md_op = 4'd1;
    u_if.a = 32'd11;
    u_if.b = 32'd13;
    #1;
    check("stall_start", {63'd0, u_if.stall_req}, 64'd1);
    exp_q.push_back(model(4'd1, 32'd11, 32'd13));
    dur_q.push_back(5);
    {m_hi, m_lo} = model(4'd1, 32'd11, 32'd13);
    @(posedge clk); #1;
    u_if.md_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      check("stall_busy", {63'd0, u_if.stall_req}, 64'd1);
      check("lo_hold", {32'd0, u_if.lo}, {32'd0, old_lo});
      if (i == 2) begin
        u_if.md_op = 4'd6;
        u_if.a = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      u_if.md_op = 4'd0;
    end
    check("stall_release", {63'd0, u_if.stall_req}, 64'd0);
    check("mult_after_mtlo", {32'd0, u_if.lo}, 64'd143);
    u_if.d_md_use = 1'b0;

    // Asynchronous reset in the middle of a divide.
    issue(4'd3, 32'd1000, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check("abort_busy", {63'd0, u_if.busy}, 64'd0);
    check("abort_hilo", {u_if.hi, u_if.lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    exp_q.delete();
    dur_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    issue(4'd1, 32'd6, 32'd7);
    wait_idle();
    issue(4'd8, 32'd0, 32'd0);
    check("post_reset_mult", {u_if.hi, u_if.lo}, 64'd42);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(1, 8));
      issue(op, pick(), pick());
      if (op <= 4'd4) begin
        if ($urandom_range(0, 1) == 1) begin
          u_if.md_op = 4'($urandom_range(1, 6));
          u_if.a = $urandom;
          u_if.b = $urandom;
          @(posedge clk); #1;
          u_if.md_op = 4'd0;
        end
        wait_idle();
      end
      check("rand_hi", {32'd0, u_if.hi}, {32'd0, m_hi});
      check("rand_lo", {32'd0, u_if.lo}, {32'd0, m_lo});
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
